layer_serializer: RTL and testbench

- Parallel-to-serial bridge between two layers.
- Captures the NN parallel neuron outputs of layer k (valid vector plus packed data bus) in a single cycle.
- Streams them one word per clock, neuron 0 first, into the single-input x_valid/x_in port of layer k+1.
- A one-deep shadow buffer absorbs a new result vector that arrives while a stream is in progress, so back-to-back vectors stream without a gap.

---
 rtl/nn_pkg.sv | 15 +
 rtl/vec_buffer.sv | 47 ++++
 rtl/layer_serializer.sv | 159 +++++++++++++++
 tb/tb_layer_serializer.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// Shared types and helpers for the layer-to-layer serializer.
//   state_t : serializer FSM states
//   cnt_w   : word-counter width for an NN-word vector
package nn_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  function automatic int cnt_w(input int nn);
    return $clog2(nn);
  endfunction

endpackage

// File: rtl/vec_buffer.sv
// Vector holding register with an occupancy flag.
//   clk, rstn : clock, async active-low reset
//   load      : capture d_in and mark full (wins over clear)
//   clear     : mark empty; data is left as-is
//   d_in      : vector to capture
//   q_out     : held vector
//   full      : occupancy flag
module vec_buffer #(
  parameter int W = 160
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] d_in,
  output logic [W-1:0] q_out,
  output logic         full
);

  logic [W-1:0] data_q, data_d;
  logic         full_q, full_d;

  always_comb begin
    data_d = data_q;
    full_d = full_q;
    if (load) begin
      data_d = d_in;
      full_d = 1'b1;
    end else if (clear) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      data_q <= '0;
      full_q <= 1'b0;
    end else begin
      data_q <= data_d;
      full_q <= full_d;
    end
  end

  assign q_out = data_q;
  assign full  = full_q;

endmodule

// File: rtl/layer_serializer.sv
// Parallel-to-serial bridge between two network layers. A full result
// vector from layer k is captured in one cycle and streamed word 0 first,
// one word per clock, into layer k+1. A one-deep shadow buffer holds a
// vector that arrives mid-stream so consecutive vectors stream gap-free.
//   clk, rstn : clock, async active-low reset
//   i_valid   : per-neuron valid from layer k; any bit set is a strobe
//   i_data    : packed words, word n at i_data[n*dataWidth +: dataWidth]
//   x_valid   : serial word valid (registered)
//   x_out     : serial word (registered, holds when x_valid=0)
//   busy      : streaming or shadow occupied
//   overflow  : sticky, a vector was dropped
//   misalign  : sticky, a strobe came with i_valid not all-ones
//
// state | meaning
// IDLE  | nothing streaming, main buffer empty
// SHIFT | x_out carries main word[cnt]; cnt==NN-1 is the last word
module layer_serializer
  import nn_pkg::*;
#(
  parameter int NN        = 10,
  parameter int dataWidth = 16
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [NN-1:0]           i_valid,
  input  logic [NN*dataWidth-1:0] i_data,
  output logic                    x_valid,
  output logic [dataWidth-1:0]    x_out,
  output logic                    busy,
  output logic                    overflow,
  output logic                    misalign
);

  localparam int VW = NN * dataWidth;
  localparam int CW = cnt_w(NN);
  localparam logic [CW-1:0] LAST = CW'(NN - 1);

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d, cnt_nxt;
  logic                 x_valid_q, x_valid_d;
  logic [dataWidth-1:0] x_out_q, x_out_d;
  logic                 overflow_q, overflow_d;
  logic                 misalign_q, misalign_d;

  logic          strobe;
  logic          main_load, main_clear, main_full;
  logic [VW-1:0] main_src, main_data;
  logic          shd_load, shd_clear, shd_full;
  logic [VW-1:0] shd_data;

  assign strobe  = |i_valid;
  assign cnt_nxt = cnt_q + 1'b1;

  vec_buffer #(.W(VW)) u_main (
    .clk   (clk),
    .rstn  (rstn),
    .load  (main_load),
    .clear (main_clear),
    .d_in  (main_src),
    .q_out (main_data),
    .full  (main_full)
  );

  vec_buffer #(.W(VW)) u_shadow (
    .clk   (clk),
    .rstn  (rstn),
    .load  (shd_load),
    .clear (shd_clear),
    .d_in  (i_data),
    .q_out (shd_data),
    .full  (shd_full)
  );

  // x_out is registered, so the word for the next cycle is chosen here:
  // word 0 of a fresh vector at load time, otherwise main word[cnt+1].
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    x_valid_d  = 1'b0;
    x_out_d    = x_out_q;
    overflow_d = overflow_q;
    misalign_d = misalign_q | (strobe & ~(&i_valid));
    main_load  = 1'b0;
    main_clear = 1'b0;
    main_src   = i_data;
    shd_load   = 1'b0;
    shd_clear  = 1'b0;
    case (state_q)
      IDLE: begin
        if (strobe) begin
          main_load = 1'b1;
          x_out_d   = i_data[0 +: dataWidth];
          x_valid_d = 1'b1;
          cnt_d     = '0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        x_valid_d = 1'b1;
        if (cnt_q == LAST) begin
          if (shd_full) begin
            // Shadow drains first; a coincident strobe refills it.
            main_load = 1'b1;
            main_src  = shd_data;
            x_out_d   = shd_data[0 +: dataWidth];
            cnt_d     = '0;
            if (strobe) shd_load  = 1'b1;
            else        shd_clear = 1'b1;
          end else if (strobe) begin
            main_load = 1'b1;
            x_out_d   = i_data[0 +: dataWidth];
            cnt_d     = '0;
          end else begin
            x_valid_d  = 1'b0;
            main_clear = 1'b1;
            state_d    = IDLE;
          end
        end else begin
          x_out_d = main_data[cnt_nxt*dataWidth +: dataWidth];
          cnt_d   = cnt_nxt;
          if (strobe) begin
            if (shd_full) overflow_d = 1'b1;
            else          shd_load   = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      x_valid_q  <= 1'b0;
      x_out_q    <= '0;
      overflow_q <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      x_valid_q  <= x_valid_d;
      x_out_q    <= x_out_d;
      overflow_q <= overflow_d;
      misalign_q <= misalign_d;
    end
  end

  // Main buffer occupancy tracks SHIFT exactly.
  main_full_tracks_state: assert property (
    @(posedge clk) disable iff (!rstn) main_full == (state_q == SHIFT));

  assign x_valid  = x_valid_q;
  assign x_out    = x_out_q;
  assign busy     = (state_q == SHIFT) | shd_full;
  assign overflow = overflow_q;
  assign misalign = misalign_q;

endmodule

// File: tb/tb_layer_serializer.sv
module tb_layer_serializer;

  localparam int NN = 10;
  localparam int DW = 16;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic [NN-1:0]    i_valid = '0;
  logic [NN*DW-1:0] i_data = '0;
  logic             x_valid;
  logic [DW-1:0]    x_out;
  logic             busy;
  logic             overflow;
  logic             misalign;

  int checks = 0;
  int failures = 0;

  // Stimulus schedule: strobe at cycle offset sched_off with words base+n.
  int            n_sched;
  int            sched_off  [0:3];
  int            sched_base [0:3];
  logic [NN-1:0] sched_vld  [0:3];

  // got_*[k] = outputs during cycle T+k (T = offset 0).
  logic          got_valid [0:47];
  logic [DW-1:0] got_data  [0:47];
  logic          got_busy  [0:47];
  logic          got_ovf   [0:47];
  logic          got_mis   [0:47];

  logic [DW-1:0] exp_word [0:19];

  layer_serializer #(.NN(NN), .dataWidth(DW)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .i_valid  (i_valid),
    .i_data   (i_data),
    .x_valid  (x_valid),
    .x_out    (x_out),
    .busy     (busy),
    .overflow (overflow),
    .misalign (misalign)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    rstn = 1'b0;
    i_valid = '0;
    i_data = '0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    n_sched = 0;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) begin
      i_valid = '0;
      i_data = '0;
      for (int s = 0; s < n_sched; s++) begin
        if (sched_off[s] == k) begin
          i_valid = sched_vld[s];
          for (int w = 0; w < NN; w++) i_data[w*DW +: DW] = DW'(sched_base[s] + w);
        end
      end
      @(posedge clk);
      #1;
      got_valid[k+1] = x_valid;
      got_data[k+1]  = x_out;
      got_busy[k+1]  = busy;
      got_ovf[k+1]   = overflow;
      got_mis[k+1]   = misalign;
    end
    i_valid = '0;
    i_data = '0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (x_valid !== 1'b0) begin failures++; $display("FAIL reset_x_valid got=%b exp=0", x_valid); end
    checks++; if (x_out !== 16'h0) begin failures++; $display("FAIL reset_x_out got=%h exp=0000", x_out); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
    checks++; if (misalign !== 1'b0) begin failures++; $display("FAIL reset_misalign got=%b exp=0", misalign); end
  endtask

  task automatic test_single();
    do_reset();
    n_sched = 1;
    sched_off[0] = 0; sched_base[0] = 16'h0001; sched_vld[0] = 10'h3FF;
    run(14);
    for (int k = 1; k <= 14; k++) begin
      logic ev;
      ev = (k <= 10);
      checks++;
      if (got_valid[k] !== ev) begin failures++; $display("FAIL single_valid k=%0d got=%b exp=%b", k, got_valid[k], ev); end
      if (ev) begin
        checks++;
        if (got_data[k] !== DW'(k)) begin failures++; $display("FAIL single_word k=%0d got=%h exp=%h", k, got_data[k], DW'(k)); end
      end
    end
    checks++; if (got_busy[10] !== 1'b1) begin failures++; $display("FAIL single_busy_last got=%b exp=1", got_busy[10]); end
    checks++; if (got_busy[11] !== 1'b0) begin failures++; $display("FAIL single_busy_fall got=%b exp=0", got_busy[11]); end
    checks++; if (got_ovf[14] !== 1'b0) begin failures++; $display("FAIL single_overflow got=%b exp=0", got_ovf[14]); end
    checks++; if (got_mis[14] !== 1'b0) begin failures++; $display("FAIL single_misalign got=%b exp=0", got_mis[14]); end
  endtask

  // Two vectors: base b0 at offset 0, b1 at offset off1; third optional.
  task automatic check_twenty(input string name, input int b0, input int b1);
    for (int w = 0; w < 10; w++) begin
      exp_word[w]    = DW'(b0 + w);
      exp_word[w+10] = DW'(b1 + w);
    end
    for (int k = 1; k <= 24; k++) begin
      logic ev;
      ev = (k <= 20);
      checks++;
      if (got_valid[k] !== ev) begin failures++; $display("FAIL %s_valid k=%0d got=%b exp=%b", name, k, got_valid[k], ev); end
      if (ev) begin
        checks++;
        if (got_data[k] !== exp_word[k-1]) begin failures++; $display("FAIL %s_word k=%0d got=%h exp=%h", name, k, got_data[k], exp_word[k-1]); end
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    n_sched = 2;
    sched_off[0] = 0; sched_base[0] = 16'h0001; sched_vld[0] = 10'h3FF;
    sched_off[1] = 4; sched_base[1] = 16'h0100; sched_vld[1] = 10'h3FF;
    run(24);
    check_twenty("b2b", 16'h0001, 16'h0100);
    checks++; if (got_busy[11] !== 1'b1) begin failures++; $display("FAIL b2b_busy_mid got=%b exp=1", got_busy[11]); end
    checks++; if (got_busy[21] !== 1'b0) begin failures++; $display("FAIL b2b_busy_end got=%b exp=0", got_busy[21]); end
    checks++; if (got_ovf[24] !== 1'b0) begin failures++; $display("FAIL b2b_overflow got=%b exp=0", got_ovf[24]); end
  endtask

  task automatic test_overflow();
    do_reset();
    n_sched = 3;
    sched_off[0] = 0; sched_base[0] = 16'h0001; sched_vld[0] = 10'h3FF;
    sched_off[1] = 3; sched_base[1] = 16'h0100; sched_vld[1] = 10'h3FF;
    sched_off[2] = 5; sched_base[2] = 16'h0200; sched_vld[2] = 10'h3FF;
    run(30);
    check_twenty("ovf", 16'h0001, 16'h0100);
    for (int k = 21; k <= 30; k++) begin
      checks++;
      if (got_valid[k] !== 1'b0) begin failures++; $display("FAIL ovf_dropped_emitted k=%0d got=%b exp=0", k, got_valid[k]); end
    end
    checks++; if (got_ovf[5] !== 1'b0) begin failures++; $display("FAIL ovf_early got=%b exp=0", got_ovf[5]); end
    for (int k = 6; k <= 30; k++) begin
      checks++;
      if (got_ovf[k] !== 1'b1) begin failures++; $display("FAIL ovf_sticky k=%0d got=%b exp=1", k, got_ovf[k]); end
    end
  endtask

  task automatic test_last_word_strobe();
    do_reset();
    n_sched = 2;
    sched_off[0] = 0;  sched_base[0] = 16'h0001; sched_vld[0] = 10'h3FF;
    sched_off[1] = 10; sched_base[1] = 16'h0300; sched_vld[1] = 10'h3FF;
    run(24);
    check_twenty("last", 16'h0001, 16'h0300);
    checks++; if (got_ovf[24] !== 1'b0) begin failures++; $display("FAIL last_overflow got=%b exp=0", got_ovf[24]); end
  endtask

  task automatic test_misalign();
    do_reset();
    n_sched = 1;
    sched_off[0] = 0; sched_base[0] = 16'h0040; sched_vld[0] = 10'h00F;
    run(12);
    checks++; if (got_mis[1] !== 1'b1) begin failures++; $display("FAIL misalign_set got=%b exp=1", got_mis[1]); end
    checks++; if (got_mis[12] !== 1'b1) begin failures++; $display("FAIL misalign_sticky got=%b exp=1", got_mis[12]); end
    for (int k = 1; k <= 11; k++) begin
      logic ev;
      ev = (k <= 10);
      checks++;
      if (got_valid[k] !== ev) begin failures++; $display("FAIL misalign_valid k=%0d got=%b exp=%b", k, got_valid[k], ev); end
      if (ev) begin
        checks++;
        if (got_data[k] !== DW'(16'h0040 + k - 1)) begin failures++; $display("FAIL misalign_word k=%0d got=%h exp=%h", k, got_data[k], DW'(16'h0040 + k - 1)); end
      end
    end
  endtask

  task automatic test_reset_mid_stream();
    do_reset();
    n_sched = 1;
    sched_off[0] = 0; sched_base[0] = 16'h0001; sched_vld[0] = 10'h3FF;
    run(5);
    checks++; if (got_valid[5] !== 1'b1 || got_data[5] !== 16'h0005) begin
      failures++; $display("FAIL rst_mid_pre got=%b/%h exp=1/0005", got_valid[5], got_data[5]);
    end
    #1 rstn = 1'b0;
    #1;
    checks++; if (x_valid !== 1'b0) begin failures++; $display("FAIL rst_mid_x_valid got=%b exp=0", x_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_mid_busy got=%b exp=0", busy); end
    checks++; if (x_out !== 16'h0) begin failures++; $display("FAIL rst_mid_x_out got=%h exp=0000", x_out); end
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    n_sched = 0;
    run(15);
    for (int k = 1; k <= 15; k++) begin
      checks++;
      if (got_valid[k] !== 1'b0) begin failures++; $display("FAIL rst_mid_after k=%0d got=%b exp=0", k, got_valid[k]); end
    end
  endtask

  initial begin
    n_sched = 0;
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_last_word_strobe();
    test_misalign();
    test_reset_mid_stream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
